// File: rtl/fifo9_arbiter_pkg.sv
// ============================================================================
//  Module   : fifo9_arbiter_pkg
//  Purpose  : Shared word layout and state encodings for the 9-bit GMII
//             FIFO arbiter (word = {dv, data[7:0]}).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo9_arbiter_pkg;

  // Word layout as written by gmii2fifo9: bit 8 is the data-valid flag
  localparam int                   c_FIFO9_W    = 9;
  localparam int                   c_FIFO9_DV   = 8;
  localparam logic [c_FIFO9_W-1:0] c_FIFO9_IDLE = 9'h000;

  // Arbiter states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fifo9_arbiter.sv
// ============================================================================
//  Module   : fifo9_arbiter
//  Purpose  : Frame-granular round-robin merge of two 9-bit GMII rx FIFOs
//             into one output FIFO. Strips leading idle words, truncates
//             oversize frames and appends a fixed idle-word inter-frame gap.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo9_arbiter
  import fifo9_arbiter_pkg::*;
#(
  parameter logic [3:0]  GAP     = 4'h2,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [c_FIFO9_W-1:0] in0_dout,
  input  logic                 in0_empty,
  output logic                 in0_rd_en,
  input  logic [c_FIFO9_W-1:0] in1_dout,
  input  logic                 in1_empty,
  output logic                 in1_rd_en,
  output logic [c_FIFO9_W-1:0] out_din,
  output logic                 out_wr_en,
  input  logic                 out_full,
  output logic                 grant,
  output logic [15:0]          drop_cnt
);

  localparam logic [10:0] c_MAX_LEN = 11'(MAX_LEN);

  // Registered state
  state_t                 r_state;
  logic                   r_grant;
  logic [10:0]            r_len;
  logic [3:0]             r_gap_cnt;
  logic [15:0]            r_drop_cnt;
  logic [c_FIFO9_W-1:0]   r_out_din;
  logic                   r_out_wr_en;

  // Next-state values and pop controls
  state_t                 w_state_nxt;
  logic                   w_grant_nxt;
  logic [10:0]            w_len_nxt;
  logic [3:0]             w_gap_nxt;
  logic [15:0]            w_drop_nxt;
  logic [c_FIFO9_W-1:0]   w_din_nxt;
  logic                   w_wr_nxt;
  logic                   w_pop;
  logic                   w_pop_port;
  logic                   w_sel_valid;
  logic                   w_sel;
  logic                   w_cand;

  logic [1:0][c_FIFO9_W-1:0] w_head;
  logic [1:0]                w_empty;

  assign w_head  = {in1_dout, in0_dout};
  assign w_empty = {in1_empty, in0_empty};
  assign w_cand  = ~r_grant;

  // Pop decision and next-state computation for the whole arbiter
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_len_nxt   = r_len;
    w_gap_nxt   = r_gap_cnt;
    w_drop_nxt  = r_drop_cnt;
    w_din_nxt   = r_out_din;
    w_wr_nxt    = 1'b0;
    w_pop       = 1'b0;
    w_pop_port  = r_grant;
    w_sel_valid = 1'b0;
    w_sel       = w_cand;

    case (r_state)
      ST_IDLE: begin
        // The first non-empty candidate decides this cycle: either its idle
        // head is discarded or its frame start wins the grant.
        if (!w_empty[w_cand]) begin
          w_sel_valid = 1'b1;
          w_sel       = w_cand;
        end else if (!w_empty[r_grant]) begin
          w_sel_valid = 1'b1;
          w_sel       = r_grant;
        end
        if (w_sel_valid) begin
          if (w_head[w_sel][c_FIFO9_DV]) begin
            w_grant_nxt = w_sel;
            w_len_nxt   = 11'd0;
            w_state_nxt = ST_FWD;
          end else begin
            w_pop      = 1'b1;
            w_pop_port = w_sel;
          end
        end
      end

      ST_FWD: begin
        if (!w_empty[r_grant] && !out_full) begin
          if (w_head[r_grant][c_FIFO9_DV]) begin
            if (r_len < c_MAX_LEN) begin
              w_pop     = 1'b1;
              w_wr_nxt  = 1'b1;
              w_din_nxt = w_head[r_grant];
              w_len_nxt = r_len + 11'd1;
            end else begin
              // Oversize: leave the word in place, DROP drains the rest
              w_state_nxt = ST_DROP;
              if (r_drop_cnt != 16'hFFFF) begin
                w_drop_nxt = r_drop_cnt + 16'd1;
              end
            end
          end else begin
            w_pop       = 1'b1;
            w_gap_nxt   = GAP;
            w_state_nxt = (GAP == 4'h0) ? ST_IDLE : ST_GAP;
          end
        end
      end

      ST_DROP: begin
        // Discarding writes nothing, so the output FIFO level is irrelevant
        if (!w_empty[r_grant]) begin
          w_pop = 1'b1;
          if (!w_head[r_grant][c_FIFO9_DV]) begin
            w_gap_nxt   = GAP;
            w_state_nxt = (GAP == 4'h0) ? ST_IDLE : ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (!out_full) begin
          w_wr_nxt  = 1'b1;
          w_din_nxt = c_FIFO9_IDLE;
          w_gap_nxt = r_gap_cnt - 4'd1;
          if (r_gap_cnt <= 4'd1) begin
            w_gap_nxt   = 4'd0;
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pops are suppressed while reset is asserted so no FIFO word is lost
  assign in0_rd_en = sys_rst && w_pop && (w_pop_port == 1'b0);
  assign in1_rd_en = sys_rst && w_pop && (w_pop_port == 1'b1);

  // State register and registered output stage
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= 1'b1;
      r_len       <= 11'd0;
      r_gap_cnt   <= 4'd0;
      r_drop_cnt  <= 16'd0;
      r_out_din   <= c_FIFO9_IDLE;
      r_out_wr_en <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_len       <= w_len_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_drop_cnt  <= w_drop_nxt;
      r_out_din   <= w_din_nxt;
      r_out_wr_en <= w_wr_nxt;
    end
  end

  assign out_din   = r_out_din;
  assign out_wr_en = r_out_wr_en;
  assign grant     = r_grant;
  assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fifo9_arbiter.sv
// ============================================================================
//  Module   : tb_fifo9_arbiter
//  Purpose  : Self-checking bench for fifo9_arbiter: FWFT input FIFO models,
//             expected-output scoreboard, table of frame scenarios plus
//             hand-written stall and mid-frame reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo9_arbiter;

  localparam int MAXL = 64;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [8:0]  in0_dout = 9'h0, in1_dout = 9'h0;
  logic        in0_empty = 1'b1, in1_empty = 1'b1;
  logic        in0_rd_en, in1_rd_en;
  logic [8:0]  out_din;
  logic        out_wr_en;
  logic        out_full = 1'b0;
  logic        grant;
  logic [15:0] drop_cnt;

  fifo9_arbiter #(.GAP(4'h2), .MAX_LEN(MAXL)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in0_dout  (in0_dout),
    .in0_empty (in0_empty),
    .in0_rd_en (in0_rd_en),
    .in1_dout  (in1_dout),
    .in1_empty (in1_empty),
    .in1_rd_en (in1_rd_en),
    .out_din   (out_din),
    .out_wr_en (out_wr_en),
    .out_full  (out_full),
    .grant     (grant),
    .drop_cnt  (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [8:0]  exp_q[$];
  logic [8:0]  exp_w;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_pop0 = 0;
  int          n_pop1 = 0;
  logic        s_rd0 = 1'b0;
  logic        s_rd1 = 1'b0;
  logic        m_grant;
  logic [15:0] m_drop;

  typedef struct {
    int          len0;
    int          len1;
    int          lead0;
    logic [15:0] exp_drop;
    logic        exp_grant;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [8:0] word(input int port, input int i);
    return {1'b1, 8'(i + port * 128)};
  endfunction

  task automatic refresh();
    in0_empty = (q0.size() == 0);
    in0_dout  = in0_empty ? 9'h000 : q0[0];
    in1_empty = (q1.size() == 0);
    in1_dout  = in1_empty ? 9'h000 : q1[0];
  endtask

  // One clock: check/sample at negedge, apply FIFO pops just after posedge,
  // return at posedge+2 where the caller may drive new stimulus.
  task automatic tick(input bit chk_no_rd = 1'b0, input bit chk_no_wr = 1'b0);
    @(negedge sys_clk);
    s_rd0 = in0_rd_en;
    s_rd1 = in1_rd_en;
    if (chk_no_rd) begin
      chk("stall_rd0", {31'd0, s_rd0}, 32'd0);
      chk("stall_rd1", {31'd0, s_rd1}, 32'd0);
    end
    if (chk_no_wr) chk("stall_wr", {31'd0, out_wr_en}, 32'd0);
    if (s_rd0 && s_rd1) begin
      n_vec++; n_err++;
      $display("FAIL dual_pop: got both rd_en high, required at most one");
    end
    if ((s_rd0 && in0_empty) || (s_rd1 && in1_empty)) begin
      n_vec++; n_err++;
      $display("FAIL pop_empty: got rd_en on empty FIFO, required none");
    end
    if (out_wr_en) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_write: got %0h, required no write", out_din);
      end else begin
        exp_w = exp_q.pop_front();
        chk("out_word", {23'd0, out_din}, {23'd0, exp_w});
      end
    end
    @(posedge sys_clk);
    #1;
    if (s_rd0 && q0.size() > 0) begin void'(q0.pop_front()); n_pop0++; end
    if (s_rd1 && q1.size() > 0) begin void'(q1.pop_front()); n_pop1++; end
    refresh();
    #1;
  endtask

  task automatic push_frame(input int port, input int first, input int len, input int lead);
    for (int i = 0; i < lead; i++) begin
      if (port == 0) q0.push_back(9'h000); else q1.push_back(9'h000);
    end
    for (int i = first; i < first + len; i++) begin
      if (port == 0) q0.push_back(word(port, i)); else q1.push_back(word(port, i));
    end
    if (port == 0) q0.push_back(9'h000); else q1.push_back(9'h000);
  endtask

  // Reference: up to MAXL words forwarded, excess dropped, then two idle words
  task automatic expect_frame(input int port, input int first, input int len);
    for (int i = first; i < first + len && i < first + MAXL; i++) exp_q.push_back(word(port, i));
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h000);
    if (len > MAXL && m_drop != 16'hFFFF) m_drop++;
    m_grant = port[0];
  endtask

  task automatic wait_drain(input int max_cyc);
    int c = 0;
    while (exp_q.size() > 0 && c < max_cyc) begin tick(); c++; end
    if (exp_q.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d words outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick();
    chk("in0_drained", q0.size(), 32'd0);
    chk("in1_drained", q1.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int c;
    logic first;
    vt[0] = '{20, 20, 0, 16'd0, 1'b1};  // both ports at once, port0 first
    vt[1] = '{64,  0, 0, 16'd0, 1'b0};  // exactly MAXL words, no truncation
    vt[2] = '{ 0, 74, 0, 16'd1, 1'b1};  // oversize frame truncated
    vt[3] = '{10,  0, 0, 16'd1, 1'b0};  // next frame intact after a drop
    vt[4] = '{ 4,  0, 3, 16'd1, 1'b0};  // leading idle words stripped
    m_grant = 1'b1;
    m_drop  = 16'd0;
    refresh();

    // Reset state
    repeat (3) tick();
    chk("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
    chk("rst_din", {23'd0, out_din}, 32'd0);
    chk("rst_grant", {31'd0, grant}, 32'd1);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    sys_rst = 1'b1;
    tick();

    // Table-driven frame scenarios
    for (int i = 0; i < 5; i++) begin
      if (vt[i].len0 > 0) push_frame(0, 0, vt[i].len0, vt[i].lead0);
      if (vt[i].len1 > 0) push_frame(1, 0, vt[i].len1, 0);
      if (vt[i].len0 > 0 && vt[i].len1 > 0) begin
        first = ~m_grant;
        expect_frame(first ? 1 : 0, 0, first ? vt[i].len1 : vt[i].len0);
        expect_frame(first ? 0 : 1, 0, first ? vt[i].len0 : vt[i].len1);
      end else if (vt[i].len0 > 0) begin
        expect_frame(0, 0, vt[i].len0);
      end else begin
        expect_frame(1, 0, vt[i].len1);
      end
      wait_drain(1000);
      chk("row_drop_cnt", {16'd0, drop_cnt}, {16'd0, vt[i].exp_drop});
      chk("row_grant", {31'd0, grant}, {31'd0, vt[i].exp_grant});
    end

    // Output-full stall for 5 cycles at word 10 of a port0 frame
    base = n_pop0;
    push_frame(0, 0, 20, 0);
    expect_frame(0, 0, 20);
    c = 0;
    while (n_pop0 - base < 10 && c < 200) begin tick(); c++; end
    chk("stall_reach_w10", n_pop0 - base, 32'd10);
    out_full = 1'b1;
    for (int k = 0; k < 5; k++) tick(1'b1, k > 0);
    out_full = 1'b0;
    wait_drain(500);
    chk("stall_drop_cnt", {16'd0, drop_cnt}, {16'd0, m_drop});

    // Reset at word 30 of a port1 frame, port0 frame arriving at the same time
    base = n_pop1;
    push_frame(1, 0, 50, 0);
    for (int i = 0; i < 30; i++) exp_q.push_back(word(1, i));
    c = 0;
    while (n_pop1 - base < 30 && c < 300) begin tick(); c++; end
    chk("rst_reach_w30", n_pop1 - base, 32'd30);
    sys_rst = 1'b0;
    push_frame(0, 0, 10, 0);
    tick();
    sys_rst = 1'b1;
    m_grant = 1'b1;
    m_drop  = 16'd0;
    chk("midrst_wr_en", {31'd0, out_wr_en}, 32'd0);
    chk("midrst_rd0", {31'd0, in0_rd_en}, 32'd0);
    chk("midrst_rd1", {31'd0, in1_rd_en}, 32'd0);
    chk("midrst_grant", {31'd0, grant}, 32'd1);
    chk("midrst_drop", {16'd0, drop_cnt}, 32'd0);
    expect_frame(0, 0, 10);
    expect_frame(1, 30, 20);
    tick();
    chk("midrst_pick_p0", {31'd0, grant}, 32'd0);
    wait_drain(500);
    chk("midrst_final_grant", {31'd0, grant}, 32'd1);
    chk("midrst_final_drop", {16'd0, drop_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
